// File: rtl/mem_responder.sv
// mem_responder: arbitrates imem/dmem requests onto a single-ported RAM and returns registered hits
module mem_responder #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              imemREN,
  input  logic [ADDR_W-1:0] imemaddr,
  input  logic              dmemREN,
  input  logic              dmemWEN,
  input  logic [ADDR_W-1:0] dmemaddr,
  input  logic [DATA_W-1:0] dmemstore,
  output logic              ihit,
  output logic [DATA_W-1:0] imemload,
  output logic              dhit,
  output logic [DATA_W-1:0] dmemload,
  output logic              ram_REN,
  output logic              ram_WEN,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_store,
  input  logic [DATA_W-1:0] ram_load,
  input  logic              ram_ready,
  output logic              proto_err
);
  typedef enum logic [1:0] {IDLE, DACC, IACC, RESP} state_t;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  state_t state, next;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic wr_q;
  logic [SW-1:0] starve_cnt;
  logic [TW-1:0] wait_cnt;
  logic dreq, starved, grant_d, grant_i, acc, timeout;
  // Arbitration and next state: data wins unless a pending fetch has been starved long enough
  always_comb begin
    dreq    = dmemREN | dmemWEN;
    starved = imemREN && (starve_cnt == SW'(STARVE_MAX));
    grant_d = (state == IDLE) && dreq && !starved;
    grant_i = (state == IDLE) && !grant_d && imemREN;
    acc     = (state == DACC) || (state == IACC);
    timeout = acc && !ram_ready && (wait_cnt == TW'(TIMEOUT - 1));
    next    = grant_d ? DACC :
              grant_i ? IACC :
              (acc && ram_ready) ? RESP :
              (timeout || state == RESP) ? IDLE : state;
  end
  // State register; async reset drops the combinational strobes immediately
  always_ff @(posedge CLK or posedge RST)
    if (RST) state <= IDLE;
    else     state <= next;
  // Latched request, counters, hit pulses and load data
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      addr_q     <= '0;
      data_q     <= '0;
      wr_q       <= 1'b0;
      starve_cnt <= '0;
      wait_cnt   <= '0;
      ihit       <= 1'b0;
      dhit       <= 1'b0;
      imemload   <= '0;
      dmemload   <= '0;
      proto_err  <= 1'b0;
    end else begin
      if (grant_d) begin
        addr_q     <= dmemaddr;
        data_q     <= dmemstore;
        wr_q       <= dmemWEN;
        starve_cnt <= !imemREN ? '0 : starved ? starve_cnt : starve_cnt + 1'b1;
      end else if (grant_i) begin
        addr_q     <= imemaddr;
        wr_q       <= 1'b0;
        starve_cnt <= '0;
      end
      wait_cnt  <= (acc && next == state) ? wait_cnt + 1'b1 : '0;
      ihit      <= (state == IACC) && ram_ready && imemREN;
      dhit      <= (state == DACC) && ram_ready && dreq;
      imemload  <= ((state == IACC) && ram_ready) ? ram_load : imemload;
      dmemload  <= ((state == DACC) && ram_ready && !wr_q) ? ram_load : dmemload;
      proto_err <= (grant_d && dmemREN && dmemWEN) || timeout;
    end
  end
  assign ram_REN   = (state == IACC) || ((state == DACC) && !wr_q);
  assign ram_WEN   = (state == DACC) && wr_q;
  assign ram_addr  = acc ? addr_q : '0;
  assign ram_store = ram_WEN ? data_q : '0;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed self-checking bench for mem_responder
module tb_mem_responder;
  logic clk = 1'b0, rst = 1'b1;
  logic imemREN = 1'b0, dmemREN = 1'b0, dmemWEN = 1'b0;
  logic [31:0] imemaddr = '0, dmemaddr = '0, dmemstore = '0;
  logic ihit, dhit, ram_REN, ram_WEN, ram_ready, proto_err;
  logic [31:0] imemload, dmemload, ram_addr, ram_store, ram_load;
  int checks = 0, errors = 0;
  int lat = -1, scnt = 0;
  logic [31:0] ram_data = '0;
  int n_ihit = 0, n_dhit = 0, n_perr = 0, n_ren = 0, n_wen = 0, n_both = 0;
  logic [31:0] last_store = '0;

  mem_responder dut (
    .CLK(clk), .RST(rst),
    .imemREN(imemREN), .imemaddr(imemaddr),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .ihit(ihit), .imemload(imemload), .dhit(dhit), .dmemload(dmemload),
    .ram_REN(ram_REN), .ram_WEN(ram_WEN), .ram_addr(ram_addr), .ram_store(ram_store),
    .ram_load(ram_load), .ram_ready(ram_ready), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  // RAM model: ready after 'lat' strobe cycles; lat<0 never answers
  assign ram_ready = (ram_REN | ram_WEN) && lat >= 0 && scnt == lat;
  assign ram_load  = ram_data;
  always @(posedge clk or posedge rst)
    if (rst) scnt <= 0;
    else     scnt <= ((ram_REN | ram_WEN) && !ram_ready) ? scnt + 1 : 0;

  // Event monitor sampled mid-cycle
  always @(negedge clk) begin
    n_ihit += int'(ihit);
    n_dhit += int'(dhit);
    n_perr += int'(proto_err);
    n_ren  += int'(ram_REN);
    n_wen  += int'(ram_WEN);
    n_both += int'(ram_REN & ram_WEN);
    if (ram_WEN) last_store = ram_store;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // sel: 0 ihit, 1 dhit, 2 proto_err, 3 any hit; n = edges until seen
  task automatic wait_for(input string tag, input int sel, input int max, output int n);
    logic seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < max) begin
      tick();
      n++;
      seen = sel == 0 ? ihit : sel == 1 ? dhit : sel == 2 ? proto_err : (ihit | dhit);
    end
    if (!seen) chk({tag, "_bound"}, 32'(seen), 32'd1);
  endtask

  initial begin
    int n, i0, d0, p0, r0, w0;
    #2;
    chk("rst_ren", 32'(ram_REN), 0);
    chk("rst_wen", 32'(ram_WEN), 0);
    chk("rst_hits", 32'({ihit, dhit, proto_err}), 0);
    chk("rst_loads", imemload | dmemload | ram_addr | ram_store, 0);
    tick();
    tick();
    rst = 1'b0;

    // single fetch
    lat = 1; ram_data = 32'h2408000A;
    i0 = n_ihit; d0 = n_dhit;
    imemREN = 1'b1; imemaddr = 32'h40;
    tick();
    chk("fetch_ren", 32'(ram_REN), 1);
    chk("fetch_addr", ram_addr, 32'h40);
    wait_for("fetch", 0, 10, n);
    chk("fetch_lat", n + 1, 3);
    chk("fetch_load", imemload, 32'h2408000A);
    imemREN = 1'b0;
    tick(); tick();
    chk("fetch_nihit", n_ihit - i0, 1);
    chk("fetch_ndhit", n_dhit - d0, 0);

    // collision: data first, then fetch 3 cycles later
    lat = 0; ram_data = 32'hDEADBEEF;
    imemREN = 1'b1; dmemREN = 1'b1; dmemaddr = 32'h100; imemaddr = 32'h44;
    wait_for("coll_d", 3, 10, n);
    chk("coll_first_d", 32'(dhit), 1);
    chk("coll_first_i", 32'(ihit), 0);
    chk("coll_dload", dmemload, 32'hDEADBEEF);
    dmemREN = 1'b0;
    wait_for("coll_i", 0, 10, n);
    chk("coll_gap", n, 3);
    imemREN = 1'b0;
    tick(); tick();

    // starvation: 4 data grants, then forced fetch, then data again
    dmemWEN = 1'b1; imemREN = 1'b1; dmemaddr = 32'h180; dmemstore = 32'h5;
    for (int k = 0; k < 6; k++) begin
      wait_for("starve", 3, 10, n);
      chk($sformatf("starve_dhit%0d", k), 32'(dhit), 32'(k != 4));
      chk($sformatf("starve_gap%0d", k), n, k == 0 ? 2 : 3);
    end
    dmemWEN = 1'b0; imemREN = 1'b0;
    tick(); tick();

    // write with 5-cycle RAM latency, store data changed mid-access
    lat = 5;
    d0 = n_dhit; r0 = n_ren; w0 = n_wen;
    dmemWEN = 1'b1; dmemaddr = 32'h200; dmemstore = 32'h12345678;
    tick();
    chk("wr_addr", ram_addr, 32'h200);
    dmemstore = 32'hFFFF0000;
    wait_for("wr", 1, 20, n);
    chk("wr_lat", n + 1, 7);
    dmemWEN = 1'b0;
    tick(); tick();
    chk("wr_wen_cycles", n_wen - w0, 6);
    chk("wr_ren_cycles", n_ren - r0, 0);
    chk("wr_store", last_store, 32'h12345678);
    chk("wr_ndhit", n_dhit - d0, 1);
    chk("wr_dload_held", dmemload, 32'hDEADBEEF);

    // fetch withdrawn mid-access: completes, no ihit, load still captured
    lat = 1; ram_data = 32'h11112222;
    i0 = n_ihit;
    imemREN = 1'b1; imemaddr = 32'h80;
    tick();
    imemREN = 1'b0;
    tick(); tick(); tick(); tick();
    chk("wd_nihit", n_ihit - i0, 0);
    chk("wd_iload", imemload, 32'h11112222);

    // timeout: strobe held 64 cycles, one proto_err, no dhit, re-grant
    lat = -1;
    d0 = n_dhit; p0 = n_perr; r0 = n_ren;
    dmemREN = 1'b1; dmemaddr = 32'h300;
    wait_for("to", 2, 100, n);
    chk("to_lat", n, 65);
    chk("to_ren_cycles", n_ren - r0, 64);
    chk("to_ndhit", n_dhit - d0, 0);
    tick();
    chk("to_regrant", 32'(ram_REN), 1);
    chk("to_nperr", n_perr - p0, 1);
    lat = 0; ram_data = 32'h0BADF00D;
    wait_for("to_done", 1, 10, n);
    chk("to_done_lat", n, 1);
    chk("to_dload", dmemload, 32'h0BADF00D);
    dmemREN = 1'b0;
    tick(); tick();
    chk("no_both", n_both, 0);

    // reset mid-access: outputs drop before the next edge, fresh timeout after release
    lat = -1;
    dmemREN = 1'b1; dmemaddr = 32'h400;
    tick(); tick();
    chk("mr_ren", 32'(ram_REN), 1);
    #2 rst = 1'b1;
    #1;
    chk("mr_ren0", 32'(ram_REN), 0);
    chk("mr_addr0", ram_addr, 0);
    chk("mr_loads0", imemload | dmemload, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    wait_for("mr_to", 2, 100, n);
    chk("mr_fresh", n, 65);
    lat = 0; ram_data = 32'h600D600D;
    wait_for("mr_done", 1, 10, n);
    chk("mr_done_lat", n, 2);
    dmemREN = 1'b0;
    tick(); tick();

    // illegal read+write: write performed, proto_err in grant cycle
    d0 = n_dhit;
    dmemREN = 1'b1; dmemWEN = 1'b1; dmemaddr = 32'h500; dmemstore = 32'hA5A5A5A5;
    tick();
    chk("ill_perr", 32'(proto_err), 1);
    chk("ill_wen", 32'(ram_WEN), 1);
    chk("ill_ren", 32'(ram_REN), 0);
    chk("ill_store", ram_store, 32'hA5A5A5A5);
    tick();
    chk("ill_dhit", 32'(dhit), 1);
    chk("ill_dload_held", dmemload, 32'h600D600D);
    dmemREN = 1'b0; dmemWEN = 1'b0;
    tick(); tick();
    chk("ill_ndhit", n_dhit - d0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
